// File: rtl/char_buf_pkg.sv
// Shared constants and FSM state type for the text overlay write path.
package char_buf_pkg;

    localparam int unsigned RAM_ADDR_W = 8;
    localparam int unsigned CHAR_W     = 7;

    localparam logic [CHAR_W-1:0] CHAR_SPACE   = 7'h20;
    localparam logic [CHAR_W-1:0] CHAR_CR      = 7'h0D;
    localparam logic [CHAR_W-1:0] CHAR_LF      = 7'h0A;
    localparam logic [CHAR_W-1:0] CHAR_BS      = 7'h08;
    localparam logic [CHAR_W-1:0] CHAR_FF      = 7'h0C;
    localparam logic [CHAR_W-1:0] CURSOR_GLYPH = 7'h5F;
    localparam logic [CHAR_W-1:0] CHAR_PRINT_LO = 7'h20;
    localparam logic [CHAR_W-1:0] CHAR_PRINT_HI = 7'h7E;

    typedef enum logic [1:0] {
        ST_CLR_ALL,
        ST_IDLE,
        ST_CLR_ROW
    } char_buf_state_t;

    function automatic logic is_printable(input logic [CHAR_W-1:0] c);
        return (c >= CHAR_PRINT_LO) && (c <= CHAR_PRINT_HI);
    endfunction

endpackage

// File: rtl/char_ram16x16.sv
// 256x7 simple dual-port character RAM: synchronous write, registered read,
// read-before-write on address collision. The array itself is not reset.
module char_ram16x16
    import char_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [RAM_ADDR_W-1:0] waddr_i,
    input  logic [CHAR_W-1:0]     wdata_i,
    input  logic [RAM_ADDR_W-1:0] raddr_i,
    output logic [CHAR_W-1:0]     rdata_o
);

    logic [CHAR_W-1:0] mem_q [2**RAM_ADDR_W];
    logic [CHAR_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset so the renderer sees 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/char_buf_writer.sv
// Write side of the 16x16 text overlay: ASCII stream in, cursor tracking, char RAM.
// Optional blinking cursor glyph is enabled by defining CHAR_BUF_CURSOR_EN.
module char_buf_writer
    import char_buf_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 32_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  char_xy,
    output logic [6:0]  char_code,
    output logic [3:0]  cursor_x,
    output logic [3:0]  cursor_y
);

    if (BLINK_CYCLES < 1) begin : g_bad_blink_cfg
        $error("BLINK_CYCLES must be at least 1");
    end

    char_buf_state_t state_q;
    logic [7:0]      clr_cnt_q;
    logic [3:0]      x_q;
    logic [3:0]      y_q;
    logic            ready_q;

    logic            accept;
    logic            ram_we;
    logic [7:0]      ram_waddr;
    logic [6:0]      ram_wdata;
    logic [6:0]      ram_rdata;

    // ready_q is only ever set while in IDLE, so it doubles as the state qualifier.
    assign accept = char_valid && ready_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {y_q, x_q};
        ram_wdata = CHAR_SPACE;
        case (state_q)
            ST_CLR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
            end
            ST_CLR_ROW: begin
                ram_we    = 1'b1;
                ram_waddr = {y_q, clr_cnt_q[3:0]};
            end
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(char_in)) begin
                        ram_we    = 1'b1;
                        ram_wdata = char_in;
                    end else if (char_in == CHAR_BS && x_q != 4'd0) begin
                        ram_we    = 1'b1;
                        ram_waddr = {y_q, x_q - 4'd1};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLR_ALL;
            clr_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLR_ALL: begin
                    clr_cnt_q <= clr_cnt_q + 8'd1;
                    if (clr_cnt_q == 8'd255) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_CLR_ROW: begin
                    clr_cnt_q <= clr_cnt_q + 8'd1;
                    if (clr_cnt_q[3:0] == 4'd15) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        // A line advance moves to the next row (wrapping 15->0) and blanks it.
                        if ((is_printable(char_in) && x_q == 4'd15) || char_in == CHAR_LF) begin
                            x_q       <= '0;
                            y_q       <= y_q + 4'd1;
                            state_q   <= ST_CLR_ROW;
                            clr_cnt_q <= '0;
                            ready_q   <= 1'b0;
                        end else if (is_printable(char_in)) begin
                            x_q <= x_q + 4'd1;
                        end else if (char_in == CHAR_CR) begin
                            x_q <= '0;
                        end else if (char_in == CHAR_BS) begin
                            if (x_q != 4'd0) begin
                                x_q <= x_q - 4'd1;
                            end
                        end else if (char_in == CHAR_FF) begin
                            x_q       <= '0;
                            y_q       <= '0;
                            state_q   <= ST_CLR_ALL;
                            clr_cnt_q <= '0;
                            ready_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_CLR_ALL;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    char_ram16x16 u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (char_xy),
        .rdata_o (ram_rdata)
    );

`ifdef CHAR_BUF_CURSOR_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;
    logic [7:0]         raddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            raddr_q     <= '0;
        end else begin
            raddr_q <= char_xy;
            if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // raddr_q is aligned with the RAM output register, keeping the substitution in step.
    assign char_code = (blink_q && raddr_q == {y_q, x_q}) ? CURSOR_GLYPH : ram_rdata;
`else
    assign char_code = ram_rdata;
`endif

    assign char_ready = ready_q;
    assign cursor_x   = x_q;
    assign cursor_y   = y_q;

endmodule

// File: tb/tb_char_buf_writer.sv
// Directed self-checking bench for char_buf_writer.
module tb_char_buf_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic [3:0] cursor_x;
    logic [3:0] cursor_y;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    char_buf_writer #(.BLINK_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_xy    (char_xy),
        .char_code  (char_code),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!char_ready && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic send_char(input logic [6:0] c);
        int n;
        wait_ready(n);
        char_valid = 1'b1;
        char_in    = c;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [7:0] a, output logic [6:0] v);
        char_xy = a;
        tick();
        v = char_code;
`ifdef CHAR_BUF_CURSOR_EN
        if (v == 7'h5F && a == {cursor_y, cursor_x}) begin
            repeat (4) tick();
            v = char_code;
        end
`endif
    endtask

    // Counts cells in row r that differ from exp.
    task automatic row_bad(input logic [3:0] r, input logic [6:0] exp, output int bad);
        logic [6:0] v;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            read_cell({r, 4'(c)}, v);
            if (v !== exp) bad++;
        end
    endtask

    task automatic test_reset();
        int n;
        int bad;
        logic [6:0] v;
        rst = 1'b1; char_valid = 1'b1; char_in = 7'h00; char_xy = 8'h00;
        repeat (3) tick();
        n_checks++;
        if (char_ready !== 1'b0 || char_code !== 7'h00 || cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%0b code=%h x=%0d y=%0d required 0 00 0 0",
                     char_ready, char_code, cursor_x, cursor_y);
        end
        @(negedge clk); rst = 1'b0;
        wait_ready(n);
        n_checks++;
        if (n !== 256) begin
            n_fail++; $display("FAIL clr_all_len: got %0d cycles required 256", n);
        end
        // Asynchronous assertion while idle must drop ready without a clock edge.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (char_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: ready=%0b required 0", char_ready);
        end
        @(negedge clk); rst = 1'b0;
        repeat (100) tick();
        #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_ready(n);
        n_checks++;
        if (n !== 256) begin
            n_fail++; $display("FAIL clr_restart_len: got %0d cycles required 256", n);
        end
        char_valid = 1'b0;
        tick();
        n_checks++;
        if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
            n_fail++; $display("FAIL idle_null_code: x=%0d y=%0d required 0 0", cursor_x, cursor_y);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            read_cell(8'(a), v);
            if (v !== 7'h20) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL clr_all_content: %0d cells not 0x20 required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] v;
        char_valid = 1'b1; char_in = 7'h41; char_xy = 8'h05;
        tick();
        n_checks++;
        if (char_ready !== 1'b1 || cursor_x !== 4'd1) begin
            n_fail++; $display("FAIL b2b_first: ready=%0b x=%0d required 1 1", char_ready, cursor_x);
        end
        char_in = 7'h42; char_xy = 8'h00;
        tick();
        n_checks++;
        if (char_code !== 7'h41) begin
            n_fail++; $display("FAIL write_latency: code=%h required 41", char_code);
        end
        char_in = 7'h43; char_xy = 8'h02;
        tick();
        n_checks++;
        if (char_code !== 7'h20) begin
            n_fail++; $display("FAIL read_before_write: code=%h required 20", char_code);
        end
        char_valid = 1'b0;
        n_checks++;
        if (cursor_x !== 4'd3 || cursor_y !== 4'd0 || char_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_cursor: x=%0d y=%0d ready=%0b required 3 0 1",
                               cursor_x, cursor_y, char_ready);
        end
        read_cell(8'h00, v);
        n_checks++;
        if (v !== 7'h41) begin n_fail++; $display("FAIL cell00: got %h required 41", v); end
        read_cell(8'h01, v);
        n_checks++;
        if (v !== 7'h42) begin n_fail++; $display("FAIL cell01: got %h required 42", v); end
        read_cell(8'h02, v);
        n_checks++;
        if (v !== 7'h43) begin n_fail++; $display("FAIL cell02: got %h required 43", v); end
    endtask

    task automatic test_row_wrap();
        int n;
        int lows;
        int bad;
        send_char(7'h0D);
        n_checks++;
        if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
            n_fail++; $display("FAIL cr: x=%0d y=%0d required 0 0", cursor_x, cursor_y);
        end
        lows = 0;
        char_valid = 1'b1; char_in = 7'h58;
        for (int i = 0; i < 16; i++) begin
            if (!char_ready) lows++;
            tick();
        end
        char_valid = 1'b0;
        n_checks++;
        if (lows !== 0) begin
            n_fail++; $display("FAIL row_b2b_ready: %0d low cycles required 0", lows);
        end
        n_checks++;
        if (char_ready !== 1'b0 || cursor_x !== 4'd0 || cursor_y !== 4'd1) begin
            n_fail++; $display("FAIL row_wrap_cursor: ready=%0b x=%0d y=%0d required 0 0 1",
                               char_ready, cursor_x, cursor_y);
        end
        wait_ready(n);
        n_checks++;
        if (n !== 16) begin n_fail++; $display("FAIL clr_row_len: got %0d required 16", n); end
        row_bad(4'd0, 7'h58, bad);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL row0_x: %0d bad cells required 0", bad); end
        row_bad(4'd1, 7'h20, bad);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL row1_blank: %0d bad cells required 0", bad); end
    endtask

    task automatic test_lf_wrap();
        int n;
        int bad;
        logic [6:0] v;
        for (int i = 0; i < 14; i++) send_char(7'h0A);
        wait_ready(n);
        n_checks++;
        if (cursor_y !== 4'd15) begin n_fail++; $display("FAIL lf_to_15: y=%0d required 15", cursor_y); end
        send_char(7'h5A);
        send_char(7'h0A);
        n_checks++;
        if (cursor_x !== 4'd0 || cursor_y !== 4'd0 || char_ready !== 1'b0) begin
            n_fail++; $display("FAIL lf_wrap_cursor: x=%0d y=%0d ready=%0b required 0 0 0",
                               cursor_x, cursor_y, char_ready);
        end
        wait_ready(n);
        n_checks++;
        if (n !== 16) begin n_fail++; $display("FAIL lf_clr_len: got %0d required 16", n); end
        row_bad(4'd0, 7'h20, bad);
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL row0_cleared: %0d bad cells required 0", bad); end
        read_cell(8'hF0, v);
        n_checks++;
        if (v !== 7'h5A) begin n_fail++; $display("FAIL row15_kept: got %h required 5a", v); end
        read_cell(8'hF1, v);
        n_checks++;
        if (v !== 7'h20) begin n_fail++; $display("FAIL row15_cell1: got %h required 20", v); end
    endtask

    task automatic test_bs_ff();
        int n;
        logic [6:0] v;
        send_char(7'h51);
        send_char(7'h52);
        send_char(7'h08);
        n_checks++;
        if (cursor_x !== 4'd1) begin n_fail++; $display("FAIL bs1_x: x=%0d required 1", cursor_x); end
        read_cell(8'h01, v);
        n_checks++;
        if (v !== 7'h20) begin n_fail++; $display("FAIL bs1_cell: got %h required 20", v); end
        read_cell(8'h00, v);
        n_checks++;
        if (v !== 7'h51) begin n_fail++; $display("FAIL bs1_keep: got %h required 51", v); end
        send_char(7'h08);
        read_cell(8'h00, v);
        n_checks++;
        if (cursor_x !== 4'd0 || v !== 7'h20) begin
            n_fail++; $display("FAIL bs2: x=%0d cell=%h required 0 20", cursor_x, v);
        end
        send_char(7'h08);
        n_checks++;
        if (cursor_x !== 4'd0 || cursor_y !== 4'd0 || char_ready !== 1'b1) begin
            n_fail++; $display("FAIL bs_at_0: x=%0d y=%0d ready=%0b required 0 0 1",
                               cursor_x, cursor_y, char_ready);
        end
        send_char(7'h51);
        send_char(7'h07);
        send_char(7'h7F);
        read_cell(8'h01, v);
        n_checks++;
        if (cursor_x !== 4'd1 || char_ready !== 1'b1 || v !== 7'h20) begin
            n_fail++; $display("FAIL ignored: x=%0d ready=%0b cell=%h required 1 1 20",
                               cursor_x, char_ready, v);
        end
        send_char(7'h57);
        send_char(7'h0D);
        n_checks++;
        if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL cr_mid: x=%0d required 0", cursor_x); end
        send_char(7'h57);
        send_char(7'h0C);
        n_checks++;
        if (cursor_x !== 4'd0 || cursor_y !== 4'd0 || char_ready !== 1'b0) begin
            n_fail++; $display("FAIL ff_cursor: x=%0d y=%0d ready=%0b required 0 0 0",
                               cursor_x, cursor_y, char_ready);
        end
        wait_ready(n);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL ff_len: got %0d required 256", n); end
        read_cell(8'h00, v);
        n_checks++;
        if (v !== 7'h20) begin n_fail++; $display("FAIL ff_cell0: got %h required 20", v); end
        read_cell(8'hF0, v);
        n_checks++;
        if (v !== 7'h20) begin n_fail++; $display("FAIL ff_cellF0: got %h required 20", v); end
    endtask

`ifdef CHAR_BUF_CURSOR_EN
    task automatic test_blink();
        logic [6:0] s [16];
        int bad;
        char_xy = 8'h00;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            s[i] = char_code;
        end
        bad = 0;
        for (int i = 4; i < 16; i++) begin
            if (s[i] === s[i-4]) bad++;
            if (s[i] !== 7'h5F && s[i] !== 7'h20) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL blink_cursor: %0d bad samples required 0", bad); end
        char_xy = 8'h01;
        tick();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (char_code !== 7'h20) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL blink_other: %0d bad samples required 0", bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_row_wrap();
        test_lf_wrap();
        test_bs_ff();
`ifdef CHAR_BUF_CURSOR_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_buf_writer.md
# char_buf_writer

Write side of the 16x16 text overlay. It accepts a stream of 7-bit ASCII codes over a valid/ready handshake and interprets control codes. It maintains a cursor and stores glyph codes in an internal 16x16 character RAM. The RAM is read back by the text renderer through a registered `char_xy -> char_code` port, so the block replaces the fixed character ROM feeding the font ROM in the text-drawing path.

## Interface
Parameters:
- `BLINK_CYCLES`, default 32_500_000: clock cycles per cursor blink half-period. Used only with `CHAR_BUF_CURSOR_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `char_in`  in  7  ASCII code to write.
- `char_valid`  in  1  `char_in` valid.
- `char_ready`  out  1  block can accept a code this cycle.
- `char_xy`  in  8  renderer read address; [7:4] = row, [3:0] = column.
- `char_code`  out  7  glyph code at `char_xy`; registered.
- `cursor_x`  out  4  current cursor column.
- `cursor_y`  out  4  current cursor row.

## Operation
- Transfer: a code is accepted on a rising edge where `char_valid && char_ready`. `char_in` is ignored otherwise.
- FSM states:
  - CLR_ALL: writes space (0x20) to addresses 0..255, one per cycle; `char_ready` = 0. Entered from reset and on form feed (FF).
  - IDLE: `char_ready` = 1; processes the accepted code in the same edge.
  - CLR_ROW: writes space to the 16 cells of `cursor_y`, one per cycle; `char_ready` = 0.
- Code handling in IDLE:
  - 0x20..0x7E: written at {y,x}; x+1. When x = 15: x = 0 and a line advance occurs.
  - 0x0D (CR): x = 0.
  - 0x0A (LF): x = 0; line advance.
  - 0x08 (BS): if x > 0, x-1 and space written at the new position; if x = 0, no effect.
  - 0x0C (FF): x = y = 0; go to CLR_ALL.
  - Any other code (0x00..0x1F not listed, 0x7F): accepted, no effect.
- Line advance:
  - y < 15: y+1, then CLR_ROW for the new row.
  - y = 15: y = 0, then CLR_ROW for row 0.
  - This gives wrap-around with no scrolling. Every new row starts blank.
- Read port: `char_code` <= RAM[`char_xy`] every cycle, independent of FSM state. When a read and a write hit the same address in one cycle, the read returns the old data.
- Cursor counters are 4-bit and wrap naturally. Column/row arithmetic is unsigned.

## Timing
- Reset values: `char_ready` 0, `char_code` 0, `cursor_x` 0, `cursor_y` 0, state CLR_ALL with clear counter 0. Blink counter and blink phase are 0.
- Reset mid-operation (any state): async return to the values above. The clear restarts from address 0.
- CLR_ALL lasts exactly 256 cycles; `char_ready` = 1 on the cycle after address 255 is written.
- CLR_ROW lasts exactly 16 cycles. `char_ready` drops on the cycle after the accepting edge and rises after column 15 is written.
- Printable, CR, BS and ignored codes keep `char_ready` = 1, so back-to-back accepts are allowed.
- Write-to-visible latency: a code accepted at edge N is in RAM after edge N. A `char_xy` presented in cycle N+1 returns it at edge N+2.
- `cursor_x` and `cursor_y` update on the accepting edge.

## Configuration
- `CHAR_BUF_CURSOR_EN` defined:
  - A blink counter toggles the blink phase every `BLINK_CYCLES` cycles.
  - When the phase is 1 and the registered read address equals {`cursor_y`,`cursor_x`}, `char_code` outputs 0x5F ('_') instead of RAM data. The substitution has the same one-cycle latency.
- Not defined: no blink logic; `char_code` is always RAM data.

## Structure
- Package `char_buf_pkg`:
  - constants `CHAR_SPACE`, `CHAR_CR`, `CHAR_LF`, `CHAR_BS`, `CHAR_FF`, `CURSOR_GLYPH`;
  - FSM state enum `char_buf_state_t`.
- Sub-module `char_ram16x16`: 256x7 simple dual-port RAM with one synchronous write port and one registered read port, read-before-write. No reset on the array.

## Test plan
- Release reset, hold `char_valid` = 1 -> `char_ready` rises exactly 256 cycles later; reads of all 256 addresses return 0x20.
- Send "AB" back-to-back -> RAM[0x00] = 0x41, RAM[0x01] = 0x42; `cursor_x` = 2, `cursor_y` = 0; `char_ready` stays 1.
- Send 16 × 'X' at row 0 -> cursor at (0,1); `char_ready` low for 16 cycles; row 1 reads all 0x20.
- With cursor at row 15, send LF -> `cursor_y` = 0; row 0 is cleared to 0x20; row 15 contents are retained.
- Send 'Q' then BS -> cell 0x00 = 0x20 and `cursor_x` = 0; a second BS has no effect. Send FF -> full 256-cycle clear and cursor at (0,0).
- With `CHAR_BUF_CURSOR_EN` and `BLINK_CYCLES` = 4: reading the cursor address alternates between 0x5F and 0x20 every 4 cycles; other addresses are unaffected.
